// File: rtl/axil_access_arbiter.sv
// axil_access_arbiter: shares one AXI-Lite master port among NUM_REQ single-beat requesters.
// Latency: grant is combinational in IDLE, AW/W or AR valid next cycle, rsp_valid one cycle after B/R handshake.
// Backpressure: one transaction in flight; req_ready withheld until IDLE; AXI valids held until accepted.
// Build option AXIL_ARB_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed lowest-index priority).
module axil_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
  output logic [2:0]                       m_axil_awprot,
  output logic                             m_axil_awvalid,
  input  logic                             m_axil_awready,
  output logic [DATA_WIDTH-1:0]            m_axil_wdata,
  output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
  output logic                             m_axil_wvalid,
  input  logic                             m_axil_wready,
  input  logic [1:0]                       m_axil_bresp,
  input  logic                             m_axil_bvalid,
  output logic                             m_axil_bready,
  output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
  output logic [2:0]                       m_axil_arprot,
  output logic                             m_axil_arvalid,
  input  logic                             m_axil_arready,
  input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
  input  logic [1:0]                       m_axil_rresp,
  input  logic                             m_axil_rvalid,
  output logic                             m_axil_rready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;

  logic                    gnt_vld;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [STRB_WIDTH-1:0]   sel_wstrb;
  logic [NUM_REQ-1:0]      idx_onehot;
  logic                    aw_done, w_done;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]        ptr_q, ptr_d, cand;

  // Round-robin: scan from the pointer; the requester closest after it wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // Move the pointer just past each winner so every requester gets its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == IDLE && gnt_vld) begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end
`endif

  // Mux the winner's command fields out of the packed request buses.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // Accept pulse to the winner while idle, and the one-hot of the registered owner.
  always_comb begin
    req_ready  = '0;
    idx_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = rst_n && (state_q == IDLE) && gnt_vld && (gnt_idx == IDX_W'(i));
      idx_onehot[i] = (idx_q == IDX_W'(i));
    end
  end

  // A write channel is finished once its valid is gone or is being accepted now.
  assign aw_done = !awvalid_q || m_axil_awready;
  assign w_done  = !wvalid_q  || m_axil_wready;

  // Transaction sequencer with registered AXI handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            idx_q   <= gnt_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            if (sel_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (awvalid_q && m_axil_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axil_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            resp_q      <= m_axil_bresp;
            bready_q    <= 1'b0;
            rsp_valid_q <= idx_onehot;
            state_q     <= IDLE;
          end
        end
        RD_REQ: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axil_rvalid) begin
            rdata_q     <= m_axil_rdata;
            resp_q      <= m_axil_rresp;
            rready_q    <= 1'b0;
            rsp_valid_q <= idx_onehot;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;

endmodule

// File: tb/tb_axil_access_arbiter.sv
// Bench for axil_access_arbiter: behavioural RAM slave, random requesters, reference
// model predicting winner and response at grant time, independent completion monitor.
module tb_axil_access_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   m_axil_awaddr, m_axil_araddr;
  logic [2:0]      m_axil_awprot, m_axil_arprot;
  logic            m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic            m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic            m_axil_rvalid, m_axil_rready;
  logic [DW-1:0]   m_axil_wdata, m_axil_rdata;
  logic [SW-1:0]   m_axil_wstrb;
  logic [1:0]      m_axil_bresp, m_axil_rresp;

  axil_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    longint        gcyc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int tests = 0, failed = 0;
  longint cyc = 0;

  logic [DW-1:0] model_mem [32];
  logic [DW-1:0] smem [32];
  int rr_ptr = 0;

  logic [N-1:0]  act, cwr, granted;
  logic [AW-1:0] caddr [N];
  logic [DW-1:0] cdata [N];
  logic [SW-1:0] cstrb [N];

  int gen_pct = 0, withdraw_en = 0, stall_pct = 0, exp_lat = 0;
  int bmin = 0, bmax = 0, rmin = 0, rmax = 0;
  bit hold_r = 0;

  logic hs_aw, hs_w, hs_b, hs_ar, hs_r, got_aw, got_w;
  logic [AW-1:0] cap_awaddr, cap_araddr, s_awaddr;
  logic [DW-1:0] cap_wdata, s_wdata, s_rdata;
  logic [SW-1:0] cap_wstrb, s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  int b_cnt = -1, r_cnt = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Arbitration rule: first requester found scanning upward from the pointer.
  function automatic int exp_winner(input logic [N-1:0] v, input int ptr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                               input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // The RAM slave rejects the top two addresses with SLVERR.
  function automatic logic [1:0] rule_resp(input logic [AW-1:0] a);
    return (a >= AW'(30)) ? 2'b10 : 2'b00;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = act[i];
      req_write[i]            = cwr[i];
      req_addr[i*AW +: AW]    = caddr[i];
      req_wdata[i*DW +: DW]   = cdata[i];
      req_wstrb[i*SW +: SW]   = cstrb[i];
    end
  endtask

  task automatic clear_slave();
    got_aw = 0; got_w = 0; b_cnt = -1; r_cnt = -1;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    m_axil_bvalid = 0; m_axil_rvalid = 0; m_axil_bresp = 0; m_axil_rresp = 0; m_axil_rdata = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
  endtask

  // One clock: update slave and requesters just after the edge, sample and predict mid-cycle.
  task automatic step();
    int w;
    exp_t e;
    logic [N-1:0] oh;
    @(posedge clk); #1; cyc++;
    if (hs_b) m_axil_bvalid = 0;
    if (hs_r) m_axil_rvalid = 0;
    if (hs_aw) begin got_aw = 1; s_awaddr = cap_awaddr; end
    if (hs_w)  begin got_w = 1; s_wdata = cap_wdata; s_wstrb = cap_wstrb; end
    if (got_aw && got_w) begin
      got_aw = 0; got_w = 0;
      s_bresp = rule_resp(s_awaddr);
      if (s_bresp == 2'b00) smem[s_awaddr] = apply_strb(smem[s_awaddr], s_wdata, s_wstrb);
      b_cnt = $urandom_range(bmin, bmax);
    end
    if (b_cnt == 0) begin m_axil_bvalid = 1; m_axil_bresp = s_bresp; b_cnt = -1; end
    else if (b_cnt > 0) b_cnt--;
    if (hs_ar) begin
      s_rresp = rule_resp(cap_araddr);
      s_rdata = (s_rresp == 2'b00) ? smem[cap_araddr] : '0;
      r_cnt = $urandom_range(rmin, rmax);
    end
    if (r_cnt == 0 && !hold_r) begin
      m_axil_rvalid = 1; m_axil_rdata = s_rdata; m_axil_rresp = s_rresp; r_cnt = -1;
    end else if (r_cnt > 0) r_cnt--;
    m_axil_awready = ($urandom_range(0, 99) >= stall_pct);
    m_axil_wready  = ($urandom_range(0, 99) >= stall_pct);
    m_axil_arready = ($urandom_range(0, 99) >= stall_pct);
    for (int i = 0; i < N; i++) begin
      if (granted[i]) act[i] = 0;
      else if (act[i] && withdraw_en != 0 && $urandom_range(0, 19) == 0) act[i] = 0;
      if (!act[i] && $urandom_range(0, 99) < gen_pct) begin
        act[i] = 1; cwr[i] = 1'($urandom_range(0, 1));
        caddr[i] = AW'($urandom_range(0, 31)); cdata[i] = $urandom; cstrb[i] = SW'($urandom_range(0, 15));
      end
    end
    drive_reqs();
    @(negedge clk);
    hs_aw = m_axil_awvalid && m_axil_awready; cap_awaddr = m_axil_awaddr;
    hs_w  = m_axil_wvalid && m_axil_wready;   cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
    hs_b  = m_axil_bvalid && m_axil_bready;
    hs_ar = m_axil_arvalid && m_axil_arready; cap_araddr = m_axil_araddr;
    hs_r  = m_axil_rvalid && m_axil_rready;
    granted = '0;
    if (!rst_n) chk("reset_no_grant", req_ready, 0);
    else if (sb.size() == 0 || rsp_valid != 0) begin
      w = exp_winner(req_valid, rr_ptr);
      if (w < 0) chk("idle_no_grant", req_ready, 0);
      else begin
        oh = '0; oh[w] = 1'b1;
        chk("grant", req_ready, oh);
        e.idx = w; e.wr = cwr[w]; e.addr = caddr[w]; e.wdata = cdata[w]; e.wstrb = cstrb[w];
        e.resp = rule_resp(caddr[w]); e.gcyc = cyc; e.lat = exp_lat; e.rdata = '0;
        if (e.wr && e.resp == 2'b00) model_mem[e.addr] = apply_strb(model_mem[e.addr], e.wdata, e.wstrb);
        if (!e.wr && e.resp == 2'b00) e.rdata = model_mem[e.addr];
        sb.push_back(e);
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        rr_ptr = (w + 1) % N;
`endif
        granted = req_ready;
      end
    end else chk("busy_no_grant", req_ready, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((sb.size() != 0 || act != 0) && n < bound) begin step(); n++; end
    tests++;
    if (sb.size() != 0 || act != 0) begin
      failed++;
      $display("FAIL drain_timeout: outstanding=%0d pending=%b after %0d cycles", sb.size(), act, n);
    end
  endtask

  task automatic issue(input int i, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    act[i] = 1; cwr[i] = wr; caddr[i] = a; cdata[i] = d; cstrb[i] = s;
    wait_idle(50);
  endtask

  // Completion monitor: pops the scoreboard on every rsp_valid and watches AXI-side rules.
  logic p_aw = 0, p_w = 0, p_ar = 0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (rsp_valid != 0) begin
          if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            e = sb.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            chk("rsp_valid", rsp_valid, oh);
            chk("rsp_resp", rsp_resp, e.resp);
            if (!e.wr) chk("rsp_rdata", rsp_rdata, e.rdata);
            if (e.lat > 0) chk("latency", 64'(cyc - e.gcyc), 64'(e.lat));
          end
        end
        if (p_aw) chk("aw_hold", {m_axil_awvalid, m_axil_awaddr}, {1'b1, p_awaddr});
        if (p_w)  chk("w_hold", {m_axil_wvalid, m_axil_wdata}, {1'b1, p_wdata});
        if (p_ar) chk("ar_hold", {m_axil_arvalid, m_axil_araddr}, {1'b1, p_araddr});
        if (sb.size() > 0) begin
          if (m_axil_awvalid && m_axil_awready) chk("awaddr", m_axil_awaddr, sb[0].addr);
          if (m_axil_wvalid && m_axil_wready) chk("wdata", {m_axil_wstrb, m_axil_wdata}, {sb[0].wstrb, sb[0].wdata});
          if (m_axil_arvalid && m_axil_arready) chk("araddr", m_axil_araddr, sb[0].addr);
          if (m_axil_bready) chk("bready_on_write", sb[0].wr, 1);
          if (m_axil_rready) chk("rready_on_read", sb[0].wr, 0);
        end
        p_aw = m_axil_awvalid && !m_axil_awready; p_awaddr = m_axil_awaddr;
        p_w  = m_axil_wvalid && !m_axil_wready;   p_wdata  = m_axil_wdata;
        p_ar = m_axil_arvalid && !m_axil_arready; p_araddr = m_axil_araddr;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n, bcnt;
    rst_n = 0;
    act = '0; cwr = '0; granted = '0;
    for (int i = 0; i < N; i++) begin caddr[i] = '0; cdata[i] = '0; cstrb[i] = '0; end
    for (int a = 0; a < 32; a++) begin model_mem[a] = '0; smem[a] = '0; end
    drive_reqs();
    clear_slave();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    chk("rst_readies", {m_axil_bready, m_axil_rready}, 0);
    chk("rst_addr", {m_axil_awaddr, m_axil_araddr}, 0);
    chk("rst_wdata", {m_axil_wstrb, m_axil_wdata}, 0);
    rst_n = 1;

    // Minimum-latency directed traffic, including slave error responses.
    exp_lat = 3;
    issue(0, 1'b1, 5'd1, 32'd2345, 4'hF);
    issue(1, 1'b0, 5'd1, '0, '0);
    issue(0, 1'b1, 5'd31, 32'h1234_5678, 4'hF);
    issue(1, 1'b0, 5'd30, '0, '0);
    issue(0, 1'b1, 5'd5, 32'hAABB_CCDD, 4'b0101);
    issue(1, 1'b0, 5'd5, '0, '0);

    // B and R held off five cycles; a competing request must wait.
    bmin = 5; bmax = 5; rmin = 5; rmax = 5; exp_lat = 8;
    act = 2'b11; cwr = 2'b01; caddr[0] = 5'd7; caddr[1] = 5'd7; cdata[0] = 32'hCAFE_F00D; cstrb[0] = 4'hF;
    n = 0; bcnt = 0;
    while ((sb.size() != 0 || act != 0) && n < 100) begin
      step(); n++;
      if (m_axil_bready) bcnt++;
    end
    chk("bready_cycles", bcnt, 6);

    // Random traffic with slave stalls and requester withdrawal.
    exp_lat = 0; stall_pct = 40; bmin = 0; bmax = 3; rmin = 0; rmax = 3;
    gen_pct = 30; withdraw_en = 1;
    repeat (600) step();
    gen_pct = 0; wait_idle(200);

    // Both requesters permanently busy.
    withdraw_en = 0; gen_pct = 100;
    repeat (200) step();
    gen_pct = 0; wait_idle(300);

    // Reset while waiting for R.
    stall_pct = 0; bmax = 0; rmax = 0; hold_r = 1;
    act[1] = 1; cwr[1] = 0; caddr[1] = 5'd4;
    n = 0;
    do begin step(); n++; end while (!m_axil_rready && n < 20);
    chk("reach_rd_resp", m_axil_rready, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_arvalid", m_axil_arvalid, 0);
    chk("rst_mid_rready", m_axil_rready, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    sb.delete(); act = '0; granted = '0; hold_r = 0; rr_ptr = 0;
    clear_slave(); drive_reqs();
    repeat (3) begin step(); chk("rsp_in_reset", rsp_valid, 0); end
    rst_n = 1;
    act = 2'b11; cwr = 2'b11; caddr[0] = 5'd2; caddr[1] = 5'd3;
    cdata[0] = 32'h0000_0002; cdata[1] = 32'h0000_0003; cstrb[0] = 4'hF; cstrb[1] = 4'hF;
    step();
    chk("post_reset_grant", req_ready, 2'b01);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
